// File: rtl/logic_reduce_unit.sv
// Multi-channel bitwise reduction (AND/OR/XOR/NAND) with optional packet folding.
// Results are queued in a 2-entry output buffer behind a valid/ready handshake.
module logic_reduce_unit #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [1:0]                op,
    input  logic                      accumulate,
    output logic [WIDTH-1:0]          out_data,
    output logic [7:0]                out_beats,
    output logic                      out_valid,
    input  logic                      out_ready
);

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    // NAND shares the AND fold; its inversion happens once on the finished result.
    function automatic logic [WIDTH-1:0] base_op(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0]       sel);
        case (sel)
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] reduce_beat(input logic [CHANNELS*WIDTH-1:0] d,
                                                     input logic [1:0]                sel);
        logic [WIDTH-1:0] r;
        r = d[WIDTH-1:0];
        for (int k = 1; k < CHANNELS; k++) begin
            r = base_op(r, d[k*WIDTH +: WIDTH], sel);
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] apply_inv(input logic [WIDTH-1:0] v,
                                                   input logic [1:0]       sel);
        return (sel == OP_NAND) ? ~v : v;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [7:0]       r_cnt;

    logic             w_accept;
    logic [1:0]       w_op_eff;
    logic [WIDTH-1:0] w_beat;
    logic             w_push;
    logic [WIDTH-1:0] w_push_data;
    logic [7:0]       w_push_beats;
    logic             w_start;
    logic             w_fold;
    logic             w_close;
    logic             w_pop;

    logic [WIDTH-1:0] r_mem_data  [2];
    logic [7:0]       r_mem_beats [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;

    assign w_accept = in_valid & in_ready;
    // Mid-packet the latched op wins over whatever is on the port.
    assign w_op_eff = (r_state == S_ACCUM) ? r_op : op;
    assign w_beat   = reduce_beat(in_data, w_op_eff);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && accumulate && !in_last) w_next_state = S_ACCUM;
            S_ACCUM: if (w_accept && in_last)                w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_push       = 1'b0;
        w_push_data  = '0;
        w_push_beats = 8'd0;
        w_start      = 1'b0;
        w_fold       = 1'b0;
        w_close      = 1'b0;
        if (w_accept) begin
            if (r_state == S_IDLE) begin
                if (!accumulate || in_last) begin
                    w_push       = 1'b1;
                    w_push_data  = apply_inv(w_beat, op);
                    w_push_beats = 8'd1;
                end else begin
                    w_start = 1'b1;
                end
            end else if (in_last) begin
                w_push       = 1'b1;
                w_close      = 1'b1;
                w_push_data  = apply_inv(base_op(r_acc, w_beat, r_op), r_op);
                w_push_beats = sat_inc(r_cnt);
            end else begin
                w_fold = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= 8'd0;
            r_op  <= 2'b00;
        end else if (w_start) begin
            r_acc <= w_beat;
            r_cnt <= 8'd1;
            r_op  <= op;
        end else if (w_fold) begin
            r_acc <= base_op(r_acc, w_beat, r_op);
            r_cnt <= sat_inc(r_cnt);
        end else if (w_close) begin
            r_acc <= '0;
            r_cnt <= 8'd0;
        end
    end

    // Output buffer: two slots addressed by 1-bit read/write pointers.
    assign w_pop = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr]  <= w_push_data;
            r_mem_beats[r_wr_ptr] <= w_push_beats;
        end
    end

    assign out_valid = (r_occ != 2'd0);
    assign out_data  = out_valid ? r_mem_data[r_rd_ptr]  : '0;
    assign out_beats = out_valid ? r_mem_beats[r_rd_ptr] : 8'd0;
    // Readiness depends on stored occupancy only, never on out_ready.
    assign in_ready  = ~rst & (r_occ != 2'd2);

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Bench for logic_reduce_unit: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a packet-level queue model.
module tb_logic_reduce_unit;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [CHANNELS*WIDTH-1:0] in_data = '0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic                      in_last = 1'b0;
    logic [1:0]                op = 2'b00;
    logic                      accumulate = 1'b0;
    logic [WIDTH-1:0]          out_data;
    logic [7:0]                out_beats;
    logic                      out_valid;
    logic                      out_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    logic_reduce_unit #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .op(op), .accumulate(accumulate),
        .out_data(out_data), .out_beats(out_beats), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq_data[$];
    logic [7:0] mq_beats[$];
    logic [7:0] m_vals[$];
    bit         m_in_pkt = 0;
    logic [1:0] m_op = 2'b00;
    logic       m_acc = 1'b0;
    logic       m_rdy;
    logic [7:0] m_r, m_f;
    logic [1:0] m_o;
    int         m_n;

    function automatic logic [7:0] m_base(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] o);
        if (o == 2'b01) return a | b;
        if (o == 2'b10) return a ^ b;
        return a & b;
    endfunction

    always @(negedge clk) begin
        m_rdy = !rst && (mq_data.size() < 2);
        chk("in_ready", in_ready, m_rdy);
        chk("out_valid", out_valid, mq_data.size() > 0);
        chk("out_data", out_data, (mq_data.size() > 0) ? mq_data[0] : 8'h00);
        chk("out_beats", out_beats, (mq_beats.size() > 0) ? mq_beats[0] : 8'h00);
        if (rst) begin
            mq_data.delete();
            mq_beats.delete();
            m_vals.delete();
            m_in_pkt = 0;
        end else begin
            if (out_ready && mq_data.size() > 0) begin
                void'(mq_data.pop_front());
                void'(mq_beats.pop_front());
            end
            if (in_valid && m_rdy) begin
                if (!m_in_pkt) begin
                    m_op  = op;
                    m_acc = accumulate;
                    m_vals.delete();
                end
                m_r = in_data[7:0];
                for (int k = 1; k < CHANNELS; k++) m_r = m_base(m_r, in_data[k*8 +: 8], m_op);
                m_vals.push_back(m_r);
                if (!m_acc || in_last) begin
                    m_f = m_vals[0];
                    for (int i = 1; i < m_vals.size(); i++) m_f = m_base(m_f, m_vals[i], m_op);
                    if (m_op == 2'b11) m_f = ~m_f;
                    m_n = m_vals.size();
                    mq_data.push_back(m_f);
                    mq_beats.push_back((m_n > 255) ? 8'd255 : 8'(m_n));
                    m_in_pkt = 0;
                end else begin
                    m_in_pkt = 1;
                end
            end
        end
        m_o = m_op;
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input logic [7:0] c0, input logic [7:0] c1, input logic [1:0] o,
                        input logic a, input logic l);
        int   g;
        logic ok;
        g = 0;
        ok = 1'b0;
        in_data    = {c1, c0};
        op         = o;
        accumulate = a;
        in_last    = l;
        in_valid   = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!ok && g < 50);
        chk("beat_accept", ok, 1'b1);
    endtask

    task automatic expect_out(input string name, input logic [7:0] d, input logic [7:0] b);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_data"}, out_data, d);
        chk({name, "_beats"}, out_beats, b);
    endtask

    task automatic expect_empty(input string name);
        @(negedge clk);
        chk({name, "_empty"}, out_valid, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_beats", out_beats, 8'h00);
        chk("rst_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Single AND beat
        beat(8'hF0, 8'h3C, 2'b00, 1'b0, 1'b0);
        in_valid = 1'b0;
        expect_out("and", 8'h30, 8'd1);
        expect_empty("and_after");

        // NAND beat
        @(posedge clk); #1;
        beat(8'hFF, 8'h0F, 2'b11, 1'b0, 1'b0);
        in_valid = 1'b0;
        expect_out("nand", 8'hF0, 8'd1);
        expect_empty("nand_after");

        // XOR accumulate of three beats
        @(posedge clk); #1;
        beat(8'h01, 8'h02, 2'b10, 1'b1, 1'b0);
        beat(8'h04, 8'h00, 2'b10, 1'b1, 1'b0);
        beat(8'h10, 8'h10, 2'b10, 1'b1, 1'b1);
        in_valid = 1'b0;
        expect_out("xor_acc", 8'h07, 8'd3);
        expect_empty("xor_acc_after");

        // OR packet with op switched mid-packet
        @(posedge clk); #1;
        beat(8'h01, 8'h00, 2'b01, 1'b1, 1'b0);
        beat(8'h02, 8'h00, 2'b00, 1'b1, 1'b1);
        in_valid = 1'b0;
        expect_out("op_latch", 8'h03, 8'd2);
        expect_empty("op_latch_after");

        // Backpressure: two results fill the buffer, third beat waits
        @(posedge clk); #1;
        out_ready = 1'b0;
        beat(8'hFF, 8'h0F, 2'b00, 1'b0, 1'b0);
        beat(8'hF0, 8'hF0, 2'b00, 1'b0, 1'b0);
        in_data = {8'hFF, 8'h3C};
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_ready", in_ready, 1'b0);
            chk("full_hold", out_data, 8'h0F);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain0", out_data, 8'h0F);
        chk("drain0_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("drain1", out_data, 8'hF0);
        chk("drain1_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        expect_out("drain2", 8'h3C, 8'd1);
        expect_empty("drain_after");

        // Saturating beat count
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++) beat(8'hFF, 8'hFF, 2'b00, 1'b1, i == 299);
        in_valid = 1'b0;
        expect_out("sat", 8'hFF, 8'd255);
        expect_empty("sat_after");

        // Reset mid-packet with one result buffered
        @(posedge clk); #1;
        out_ready = 1'b0;
        beat(8'h11, 8'h11, 2'b00, 1'b0, 1'b0);
        beat(8'h01, 8'h01, 2'b01, 1'b1, 1'b0);
        beat(8'h02, 8'h02, 2'b01, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_data", out_data, 8'h00);
        chk("midrst_beats", out_beats, 8'h00);
        @(posedge clk); #1;
        out_ready = 1'b1;
        beat(8'hAA, 8'hFF, 2'b00, 1'b1, 1'b1);
        in_valid = 1'b0;
        expect_out("post_rst", 8'hAA, 8'd1);
        expect_empty("post_rst_after");

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk); #1;
            rst        = ($urandom_range(0, 199) == 0);
            in_valid   = ($urandom_range(0, 2) != 0);
            in_data    = 16'($urandom);
            op         = 2'($urandom_range(0, 3));
            accumulate = 1'($urandom_range(0, 1));
            in_last    = ($urandom_range(0, 3) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
